// File: rtl/prodcons_pkg.sv
// rtl/prodcons_pkg.sv - shared types and data-word helper for the producer/consumer block
package prodcons_pkg;

    localparam int CH_ID_W = 8;
    // Upper bound on data width handled by make_data; callers truncate the result.
    localparam int DW_MAX  = 1024;

    typedef enum logic [2:0] {
        PS_IDLE,
        PS_OFFER,
        PS_GAP,
        PS_BACKOFF,
        PS_DONE,
        PS_FAIL
    } pstate_t;

    typedef enum logic [1:0] {
        CS_WAIT,
        CS_RESP,
        CS_HOLD
    } cstate_t;

    // Data word = {channel id, sequence number}; dw is the real data width.
    function automatic logic [DW_MAX-1:0] make_data(
        input logic [CH_ID_W-1:0] ch,
        input logic [DW_MAX-1:0]  seq,
        input int unsigned        dw
    );
        logic [DW_MAX-1:0] mask;
        mask = (DW_MAX'(1) << (dw - CH_ID_W)) - DW_MAX'(1);
        return (DW_MAX'(ch) << (dw - CH_ID_W)) | (seq & mask);
    endfunction

endpackage

// File: rtl/prodcons_pchan.sv
// rtl/prodcons_pchan.sv - one producer channel: offer/gap/back-off FSM with bounded retry
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   i_start          arm pulse (already gated by the top while busy)
//   i_num_items      items to send, sampled on i_start
//   i_crdy, i_cerr   consumer accept / reject
//   o_prdy, o_data   offer and data word (data is zero when not offering)
//   o_done, o_fail, o_busy  channel status
module prodcons_pchan
    import prodcons_pkg::*;
#(
    parameter int C_CH          = 0,
    parameter int C_DATA_WIDTH  = 32,
    parameter int C_RETRY_DELAY = 32,
    parameter int C_MAX_RETRY   = 7,
    parameter int C_CNT_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_start,
    input  logic [C_CNT_WIDTH-1:0]  i_num_items,
    input  logic                    i_crdy,
    input  logic                    i_cerr,
    output logic                    o_prdy,
    output logic [C_DATA_WIDTH-1:0] o_data,
    output logic                    o_done,
    output logic                    o_fail,
    output logic                    o_busy
);

    localparam int SEQ_W = C_DATA_WIDTH - CH_ID_W;
    localparam int RET_W = (C_MAX_RETRY < 1) ? 1 : $clog2(C_MAX_RETRY + 1);
    localparam int TMR_W = $clog2(C_RETRY_DELAY + 1);

    pstate_t            r_state;
    logic [SEQ_W-1:0]   r_seq;
    logic [C_CNT_WIDTH-1:0] r_left;
    logic [RET_W-1:0]   r_retry;
    logic [TMR_W-1:0]   r_tmr;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= PS_IDLE;
            r_seq   <= '0;
            r_left  <= '0;
            r_retry <= '0;
            r_tmr   <= '0;
        end else begin
            case (r_state)
                PS_IDLE, PS_DONE, PS_FAIL: begin
                    if (i_start) begin
                        r_seq   <= '0;
                        r_retry <= '0;
                        r_left  <= i_num_items;
                        r_state <= (i_num_items == '0) ? PS_DONE : PS_OFFER;
                    end
                end
                PS_OFFER: begin
                    // Accept takes priority over reject when both arrive together.
                    if (i_crdy) begin
                        r_seq   <= r_seq + SEQ_W'(1);
                        r_left  <= r_left - C_CNT_WIDTH'(1);
                        r_retry <= '0;
                        r_state <= PS_GAP;
                    end else if (i_cerr) begin
                        if (r_retry == RET_W'(C_MAX_RETRY)) begin
                            r_state <= PS_FAIL;
                        end else begin
                            r_retry <= r_retry + RET_W'(1);
                            // Timer counts down to zero, giving exactly C_RETRY_DELAY idle cycles.
                            r_tmr   <= TMR_W'(C_RETRY_DELAY - 1);
                            r_state <= PS_BACKOFF;
                        end
                    end
                end
                PS_GAP: begin
                    r_state <= (r_left == '0) ? PS_DONE : PS_OFFER;
                end
                PS_BACKOFF: begin
                    if (r_tmr == '0) begin
                        r_state <= PS_OFFER;
                    end else begin
                        r_tmr <= r_tmr - TMR_W'(1);
                    end
                end
                default: r_state <= PS_IDLE;
            endcase
        end
    end

    assign o_prdy = (r_state == PS_OFFER);
    assign o_data = o_prdy ? C_DATA_WIDTH'(make_data(CH_ID_W'(C_CH), DW_MAX'(r_seq), C_DATA_WIDTH))
                           : '0;
    assign o_done = (r_state == PS_DONE);
    assign o_fail = (r_state == PS_FAIL);
    assign o_busy = (r_state == PS_OFFER) || (r_state == PS_GAP) || (r_state == PS_BACKOFF);

endmodule

// File: rtl/prodcons_mc.sv
// rtl/prodcons_mc.sv - multi-channel producer/consumer traffic source and checking sink
// Ports:
//   clk, rstn                    clock, synchronous active-low reset
//   start, num_items             launch all producers (ignored while busy)
//   cerr_every                   consumer rejects every Nth response, 0 = never
//   p_prdy, p_crdy, p_cerr, p_data   producer side, one lane per channel
//   c_prdy, c_crdy, c_cerr, c_data   consumer side, one lane per channel
//   busy, done, p_fail           producer status
//   c_mismatch, c_count          consumer data-check status and accepted-item counts
module prodcons_mc
    import prodcons_pkg::*;
#(
    parameter int C_NUM_CH      = 4,
    parameter int C_DATA_WIDTH  = 32,
    parameter int C_RETRY_DELAY = 32,
    parameter int C_MAX_RETRY   = 7,
    parameter int C_CNT_WIDTH   = 16
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             start,
    input  logic [C_CNT_WIDTH-1:0]           num_items,
    input  logic [7:0]                       cerr_every,
    output logic [C_NUM_CH-1:0]              p_prdy,
    input  logic [C_NUM_CH-1:0]              p_crdy,
    input  logic [C_NUM_CH-1:0]              p_cerr,
    output logic [C_NUM_CH*C_DATA_WIDTH-1:0] p_data,
    input  logic [C_NUM_CH-1:0]              c_prdy,
    output logic [C_NUM_CH-1:0]              c_crdy,
    output logic [C_NUM_CH-1:0]              c_cerr,
    input  logic [C_NUM_CH*C_DATA_WIDTH-1:0] c_data,
    output logic                             busy,
    output logic                             done,
    output logic [C_NUM_CH-1:0]              p_fail,
    output logic [C_NUM_CH-1:0]              c_mismatch,
    output logic [C_NUM_CH*C_CNT_WIDTH-1:0]  c_count
);

    localparam int SEQ_W = C_DATA_WIDTH - CH_ID_W;

    logic [C_NUM_CH-1:0] w_done;
    logic [C_NUM_CH-1:0] w_busy;
    logic                w_start;

    assign w_start = start & ~busy;
    assign busy    = |w_busy;
    assign done    = &w_done;

    for (genvar g = 0; g < C_NUM_CH; g++) begin : g_ch
        prodcons_pchan #(
            .C_CH          (g),
            .C_DATA_WIDTH  (C_DATA_WIDTH),
            .C_RETRY_DELAY (C_RETRY_DELAY),
            .C_MAX_RETRY   (C_MAX_RETRY),
            .C_CNT_WIDTH   (C_CNT_WIDTH)
        ) u_pchan (
            .clk         (clk),
            .rstn        (rstn),
            .i_start     (w_start),
            .i_num_items (num_items),
            .i_crdy      (p_crdy[g]),
            .i_cerr      (p_cerr[g]),
            .o_prdy      (p_prdy[g]),
            .o_data      (p_data[g*C_DATA_WIDTH +: C_DATA_WIDTH]),
            .o_done      (w_done[g]),
            .o_fail      (p_fail[g]),
            .o_busy      (w_busy[g])
        );

        cstate_t                r_cst;
        logic [7:0]             r_ecnt;
        logic                   r_err;
        logic [SEQ_W-1:0]       r_exp;
        logic                   r_mis;
        logic [C_CNT_WIDTH-1:0] r_cnt;
        logic [7:0]             w_ecur;
        logic                   w_err_now;

        // A zero count means "reload from cerr_every" on the next response.
        assign w_ecur    = (r_ecnt == '0) ? cerr_every : r_ecnt;
        assign w_err_now = (cerr_every != '0) && (w_ecur == 8'd1);

        always_ff @(posedge clk) begin
            if (!rstn) begin
                r_cst  <= CS_WAIT;
                r_ecnt <= '0;
                r_err  <= 1'b0;
                r_exp  <= '0;
                r_mis  <= 1'b0;
                r_cnt  <= '0;
            end else begin
                case (r_cst)
                    CS_WAIT: begin
                        if (c_prdy[g]) begin
                            r_cst <= CS_RESP;
                            r_err <= w_err_now;
                            if (cerr_every != '0) begin
                                r_ecnt <= w_ecur - 8'd1;
                            end
                            // Data is checked as offered; the accept pulse follows next cycle.
                            if (!w_err_now) begin
                                if (c_data[g*C_DATA_WIDTH +: C_DATA_WIDTH] !=
                                    C_DATA_WIDTH'(make_data(CH_ID_W'(g), DW_MAX'(r_exp), C_DATA_WIDTH))) begin
                                    r_mis <= 1'b1;
                                end
                                r_exp <= r_exp + SEQ_W'(1);
                                r_cnt <= r_cnt + C_CNT_WIDTH'(1);
                            end
                        end
                    end
                    CS_RESP: r_cst <= CS_HOLD;
                    default: r_cst <= CS_WAIT;
                endcase
            end
        end

        assign c_crdy[g]     = (r_cst == CS_RESP) & ~r_err;
        assign c_cerr[g]     = (r_cst == CS_RESP) &  r_err;
        assign c_mismatch[g] = r_mis;
        assign c_count[g*C_CNT_WIDTH +: C_CNT_WIDTH] = r_cnt;
    end

endmodule

// File: tb/tb_prodcons_mc.sv
// tb/tb_prodcons_mc.sv - self-checking bench for prodcons_mc
module tb_prodcons_mc;

    localparam int NCH  = 4;
    localparam int DW   = 32;
    localparam int RD   = 32;
    localparam int MR   = 7;
    localparam int CW   = 16;
    localparam int SMSK = (1 << (DW - 8)) - 1;

    logic              clk = 1'b0;
    logic              rstn;
    logic              start;
    logic [CW-1:0]     num_items;
    logic [7:0]        cerr_every;
    logic [NCH-1:0]    p_prdy, p_crdy, p_cerr, c_prdy, c_crdy, c_cerr;
    logic [NCH*DW-1:0] p_data, c_data;
    logic              busy, done;
    logic [NCH-1:0]    p_fail, c_mismatch;
    logic [NCH*CW-1:0] c_count;

    logic              lb;
    logic [NCH-1:0]    t_p_crdy, t_p_cerr, t_c_prdy;
    logic [NCH*DW-1:0] t_c_data;

    assign p_crdy = lb ? c_crdy : t_p_crdy;
    assign p_cerr = lb ? c_cerr : t_p_cerr;
    assign c_prdy = lb ? p_prdy : t_c_prdy;
    assign c_data = lb ? p_data : t_c_data;

    prodcons_mc #(
        .C_NUM_CH(NCH), .C_DATA_WIDTH(DW), .C_RETRY_DELAY(RD),
        .C_MAX_RETRY(MR), .C_CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .num_items(num_items),
        .cerr_every(cerr_every), .p_prdy(p_prdy), .p_crdy(p_crdy),
        .p_cerr(p_cerr), .p_data(p_data), .c_prdy(c_prdy), .c_crdy(c_crdy),
        .c_cerr(c_cerr), .c_data(c_data), .busy(busy), .done(done),
        .p_fail(p_fail), .c_mismatch(c_mismatch), .c_count(c_count)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    int n_cerr0 = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: per-channel counters of what the protocol rules demand.
    // m_act: 0 idle, 1 running, 2 done, 3 failed. m_quiet: cycles prdy must stay low.
    int m_act[NCH], m_seq[NCH], m_left[NCH], m_retry[NCH], m_quiet[NCH];
    int k_pend[NCH], k_ign[NCH], k_nresp[NCH], k_exp[NCH], k_cnt[NCH];
    bit k_err[NCH], k_mis[NCH];

    initial begin
        for (int i = 0; i < NCH; i++) begin
            m_act[i] = 0; m_seq[i] = 0; m_left[i] = 0; m_retry[i] = 0; m_quiet[i] = 0;
            k_pend[i] = 0; k_ign[i] = 0; k_nresp[i] = 0; k_exp[i] = 0; k_cnt[i] = 0;
            k_err[i] = 0; k_mis[i] = 0;
        end
    end

    always @(negedge clk) begin
        bit ep, mbusy, mdone, e;
        mbusy = 0; mdone = 1;
        for (int i = 0; i < NCH; i++) begin
            ep = (m_act[i] == 1) && (m_quiet[i] == 0);
            chk($sformatf("p_prdy%0d", i), 128'(p_prdy[i]), 128'(ep));
            if (ep && p_prdy[i])
                chk($sformatf("p_data%0d", i), 128'(p_data[i*DW +: DW]),
                    128'({8'(i), 24'(m_seq[i])}));
            chk($sformatf("p_fail%0d", i), 128'(p_fail[i]), 128'(m_act[i] == 3));
            chk($sformatf("c_crdy%0d", i), 128'(c_crdy[i]), 128'(k_pend[i] != 0 && !k_err[i]));
            chk($sformatf("c_cerr%0d", i), 128'(c_cerr[i]), 128'(k_pend[i] != 0 && k_err[i]));
            chk($sformatf("c_mismatch%0d", i), 128'(c_mismatch[i]), 128'(k_mis[i]));
            chk($sformatf("c_count%0d", i), 128'(c_count[i*CW +: CW]), 128'(k_cnt[i] & 16'hFFFF));
            if (m_act[i] == 1) mbusy = 1;
            if (m_act[i] != 2) mdone = 0;
        end
        chk("busy", 128'(busy), 128'(mbusy));
        chk("done", 128'(done), 128'(mdone));

        if (!rstn) begin
            for (int i = 0; i < NCH; i++) begin
                m_act[i] = 0; m_seq[i] = 0; m_left[i] = 0; m_retry[i] = 0; m_quiet[i] = 0;
                k_pend[i] = 0; k_ign[i] = 0; k_nresp[i] = 0; k_exp[i] = 0; k_cnt[i] = 0;
                k_err[i] = 0; k_mis[i] = 0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (m_act[i] == 1) begin
                    if (m_quiet[i] > 0) begin
                        m_quiet[i]--;
                        if (m_quiet[i] == 0 && m_left[i] == 0) m_act[i] = 2;
                    end else if (p_crdy[i]) begin
                        m_seq[i] = (m_seq[i] + 1) & SMSK;
                        m_left[i]--;
                        m_retry[i] = 0;
                        m_quiet[i] = 1;
                    end else if (p_cerr[i]) begin
                        if (m_retry[i] == MR) m_act[i] = 3;
                        else begin m_retry[i]++; m_quiet[i] = RD; end
                    end
                end
                if (start && !mbusy) begin
                    m_act[i] = (num_items == 0) ? 2 : 1;
                    m_seq[i] = 0; m_left[i] = int'(num_items); m_retry[i] = 0; m_quiet[i] = 0;
                end
                if (k_pend[i] != 0) begin
                    k_pend[i] = 0; k_ign[i] = 1;
                end else if (k_ign[i] != 0) begin
                    k_ign[i] = 0;
                end else if (c_prdy[i]) begin
                    e = (cerr_every != 0) && ((k_nresp[i] % int'(cerr_every)) == int'(cerr_every) - 1);
                    k_pend[i] = 1; k_err[i] = e; k_nresp[i]++;
                    if (!e) begin
                        if (c_data[i*DW +: DW] !== {8'(i), 24'(k_exp[i])}) k_mis[i] = 1;
                        k_exp[i] = (k_exp[i] + 1) & SMSK;
                        k_cnt[i]++;
                    end
                end
            end
        end
    end

    always @(negedge clk) if (c_cerr[0] === 1'b1) n_cerr0++;

    task automatic do_reset();
        @(posedge clk); #1;
        rstn = 1'b0; start = 1'b0; t_p_crdy = '0; t_p_cerr = '0; t_c_prdy = '0; t_c_data = '0;
        @(posedge clk); #1;
        rstn = 1'b1; n_cerr0 = 0;
    endtask

    task automatic pulse_start(input int n);
        @(posedge clk); #1;
        num_items = CW'(n); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int lim);
        int k;
        k = 0;
        do begin @(negedge clk); k++; end while (busy !== 1'b0 && k < lim);
        chk({nm, "_idle"}, 128'(busy), 128'(0));
    endtask

    task automatic wait_prdy(input int ch, input int lim);
        int k;
        k = 0;
        do begin @(negedge clk); k++; end while (p_prdy[ch] !== 1'b1 && k < lim);
        chk($sformatf("wait_prdy%0d", ch), 128'(p_prdy[ch]), 128'(1));
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_prdy"}, 128'(p_prdy), 128'(0));
        chk({nm, "_pdata"}, 128'(p_data), 128'(0));
        chk({nm, "_resp"}, 128'({c_crdy, c_cerr}), 128'(0));
        chk({nm, "_stat"}, 128'({busy, done, p_fail, c_mismatch}), 128'(0));
        chk({nm, "_count"}, 128'(c_count), 128'(0));
    endtask

    initial begin
        bit seen;
        int k;
        rstn = 1'b0; start = 1'b0; num_items = '0; cerr_every = 8'd0; lb = 1'b1;
        t_p_crdy = '0; t_p_cerr = '0; t_c_prdy = '0; t_c_data = '0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk_all_zero("reset");

        // Loopback, no injection, 5 items.
        cerr_every = 8'd0;
        pulse_start(5);
        wait_prdy(1, 10);
        chk("t1_first_ch1", 128'(p_data[63:32]), 128'(32'h0100_0000));
        wait_idle("t1", 200);
        chk("t1_count", 128'(c_count), 128'(64'h0005_0005_0005_0005));
        chk("t1_done", 128'({done, c_mismatch}), 128'(5'b1_0000));

        // Every 3rd response rejected, 4 items: one cerr per channel.
        do_reset();
        cerr_every = 8'd3;
        pulse_start(4);
        wait_idle("t2", 400);
        chk("t2_count", 128'(c_count), 128'(64'h0004_0004_0004_0004));
        chk("t2_cerr0", 128'(n_cerr0), 128'(1));
        chk("t2_done", 128'({done, c_mismatch}), 128'(5'b1_0000));

        // Every response rejected: fail after C_MAX_RETRY+1 cerrs.
        do_reset();
        cerr_every = 8'd1;
        pulse_start(3);
        wait_idle("t3", 1000);
        chk("t3_fail", 128'(p_fail), 128'(4'hF));
        chk("t3_done", 128'({done, busy}), 128'(0));
        chk("t3_cerr0", 128'(n_cerr0), 128'(8));

        // Simultaneous accept and reject on ch2: accept wins.
        do_reset();
        lb = 1'b0; cerr_every = 8'd0;
        pulse_start(2);
        wait_prdy(2, 10);
        @(posedge clk); #1;
        t_p_crdy = 4'b0100; t_p_cerr = 4'b0100;
        @(posedge clk); #1;
        t_p_crdy = '0; t_p_cerr = '0;
        wait_prdy(2, 10);
        chk("t4_seq", 128'(p_data[95:64]), 128'(32'h0200_0001));
        chk("t4_fail", 128'(p_fail), 128'(0));

        // Out-of-order data on consumer ch0.
        do_reset();
        @(posedge clk); #1;
        t_c_prdy = 4'b0001; t_c_data = '0;
        @(posedge clk); #1;
        t_c_prdy = '0;
        repeat (4) @(posedge clk);
        #1 t_c_prdy = 4'b0001; t_c_data[31:0] = 32'h0000_0002;
        @(posedge clk); #1;
        t_c_prdy = '0;
        repeat (3) @(negedge clk);
        chk("t5_mis", 128'(c_mismatch), 128'(4'b0001));
        chk("t5_count", 128'(c_count), 128'(64'h0000_0000_0000_0002));

        // Reset while ch1 backs off: everything clears and nothing is re-offered.
        do_reset();
        lb = 1'b1; cerr_every = 8'd1;
        pulse_start(4);
        k = 0;
        do begin @(negedge clk); k++; end while (c_cerr[1] !== 1'b1 && k < 20);
        chk("t6_cerr1", 128'(c_cerr[1]), 128'(1));
        repeat (5) @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        @(negedge clk);
        chk_all_zero("t6_rst");
        seen = 0;
        repeat (40) begin @(negedge clk); if (p_prdy !== '0) seen = 1; end
        chk("t6_no_reoffer", 128'(seen), 128'(0));

        // Start while busy is ignored.
        cerr_every = 8'd0;
        pulse_start(5);
        repeat (3) @(posedge clk);
        pulse_start(1);
        wait_idle("t7", 200);
        chk("t7_count", 128'(c_count), 128'(64'h0005_0005_0005_0005));
        chk("t7_done", 128'(done), 128'(1));

        // Randomized loopback runs.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            lb = 1'b1;
            cerr_every = 8'($urandom_range(0, 4));
            pulse_start(int'($urandom_range(0, 6)));
            wait_idle($sformatf("rnd%0d", r), 1500);
        end

        // Randomized external responder and upstream source.
        do_reset();
        lb = 1'b0; cerr_every = 8'd2;
        pulse_start(3);
        repeat (400) begin
            @(posedge clk); #1;
            t_p_crdy = 4'($urandom) & 4'($urandom);
            t_p_cerr = 4'($urandom) & 4'($urandom);
            t_c_prdy = 4'($urandom);
            for (int i = 0; i < NCH; i++)
                t_c_data[i*DW +: DW] = {8'(i), 24'($urandom_range(0, 3))};
        end
        do_reset();
        lb = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/prodcons_mc.md
Name: prodcons_mc

Overview:
Synthesisable, multi-channel successor to the behavioural producer/consumer thread generator in the XDRS demo.
- Drives C_NUM_CH independent producer channels using the prdy/crdy/cerr handshake, with bounded retry and back-off.
- Serves C_NUM_CH consumer channels with programmable error injection and in-order data checking.
- Sits beside reconfigurable regions as a traffic source/sink for stress and loopback testing.

Parameters:
C_NUM_CH, 4, number of producer channels and of consumer channels (1..256)
C_DATA_WIDTH, 32, data width per channel (>=16)
C_RETRY_DELAY, 32, idle cycles after a cerr before re-offering the same item (>=1)
C_MAX_RETRY, 7, cerr responses tolerated per item before the channel fails
C_CNT_WIDTH, 16, width of item and sequence counters

Ports:
clk  in  1  clock, all logic on posedge
rstn  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; launches all producers; ignored while busy
num_items  in  C_CNT_WIDTH  items per producer channel, sampled on start
cerr_every  in  8  consumer injects cerr on every Nth response; 0 = never
p_prdy  out  C_NUM_CH  producer ready, one bit per channel
p_crdy  in  C_NUM_CH  consumer accepted
p_cerr  in  C_NUM_CH  consumer rejected
p_data  out  C_NUM_CH*C_DATA_WIDTH  producer data; channel i in slice i
c_prdy  in  C_NUM_CH  upstream offers data
c_crdy  out  C_NUM_CH  accept pulse
c_cerr  out  C_NUM_CH  reject pulse
c_data  in  C_NUM_CH*C_DATA_WIDTH  upstream data
busy  out  1  any producer neither DONE nor FAIL
done  out  1  all producers DONE (sticky until next start/reset)
p_fail  out  C_NUM_CH  sticky; channel exceeded C_MAX_RETRY
c_mismatch  out  C_NUM_CH  sticky; consumer saw out-of-order or corrupt data
c_count  out  C_NUM_CH*C_CNT_WIDTH  items accepted per consumer channel

Behaviour:
- Reset (rstn=0 at posedge):
  - All outputs 0, all counters 0, all FSMs IDLE.
  - Takes effect mid-transfer too: prdy drops on the next cycle and is not re-offered.
- Data format: p_data = {ch[7:0], seq[C_DATA_WIDTH-9:0]}. seq starts at 0 per channel on each start and increments per accepted item, wrapping modulo 2^(C_DATA_WIDTH-8).
- Producer FSM per channel, states IDLE, OFFER, GAP, BACKOFF, DONE, FAIL:
  - IDLE: on start, go to DONE if num_items==0, else to OFFER. Clear seq, retry count and p_fail.
  - OFFER: p_prdy=1 with p_data stable.
    - Sampled p_crdy=1: seq++, retry=0, go to GAP. p_prdy is low the following cycle.
    - Else sampled p_cerr=1: if retry==C_MAX_RETRY, go to FAIL; else retry++ and go to BACKOFF.
    - p_crdy wins if both are asserted together.
  - GAP: one idle cycle, then OFFER if items remain, else DONE.
  - BACKOFF: p_prdy=0 for exactly C_RETRY_DELAY cycles, then OFFER with the same seq.
  - DONE, FAIL: hold; p_fail=1 in FAIL. A new start re-arms the channel.
- done = 1 when every channel is in DONE. A channel in FAIL keeps done=0 and busy=0.
- Consumer per channel, states WAIT, RESP, HOLD:
  - WAIT: on sampled c_prdy=1, go to RESP.
  - RESP: drive c_crdy=1 or c_cerr=1 for exactly one cycle (latency 1), then go to HOLD.
  - HOLD: one cycle with outputs low and c_prdy ignored, then WAIT.
  - Response choice: a per-channel down-counter is loaded with cerr_every. Each response decrements it; the response that brings it to 0 is a cerr, and the counter then reloads. cerr_every=0 disables injection.
  - On a crdy response, c_data is compared with the expected {ch, exp_seq}. A mismatch sets c_mismatch. exp_seq advances regardless; c_count increments.
  - c_count wraps modulo 2^C_CNT_WIDTH.
- start and reset re-arm producers only. Consumer state and counters are cleared only by rstn.

Decomposition:
- Package prodcons_pkg holds:
  - producer state enum and consumer state enum;
  - a function make_data(ch, seq) returning the data word;
  - CH_ID_W = 8.
- One sub-module, prodcons_pchan: the per-channel producer FSM, seq counter, retry counter and back-off timer. The top generates C_NUM_CH instances.
- The consumer logic stays inline in a generate loop in the top.

Test Plan:
- Loopback p_*→c_*, cerr_every=0, num_items=5 → each channel delivers 0x00000000..4 (ch0) and 0x01000000..4 (ch1); done after 5 items; c_count=5; no mismatch.
- cerr_every=3, num_items=4, C_RETRY_DELAY=32 → every 3rd response is a cerr; p_prdy is low exactly 32 cycles before the retry; all items arrive in order; c_count=4.
- cerr_every=1 → every response is a cerr; after 8 cerrs (C_MAX_RETRY+1) the channel enters FAIL; p_fail=1; done=0, busy=0.
- External responder asserts p_crdy and p_cerr together on ch2 → the item is accepted, seq increments, retry stays 0.
- Inject c_data seq 0,2 on ch0 → c_mismatch[0]=1 after the second item; other channels unaffected.
- rstn=0 for one cycle while ch1 is in BACKOFF, and start while busy → all outputs 0 next cycle and no re-offer; a start during busy changes nothing.
